pc_msg_parser: RTL and testbench

- Sits between xb_wr_fifo (FWFT, CLK-domain read side) and the application's command logic.
- Pops 32-bit host words, assembles 3-word host commands (LSW first), classifies them as START or STOP, and presents one 96-bit command at a time with a valid/ready handshake.
- Discards stalled partial commands via an inter-word timeout, so a short host write cannot desynchronise framing permanently.

---
 rtl/pc_msg_parser_if.sv | 46 ++++
 rtl/pc_msg_parser.sv | 163 ++++++++++++++++
 tb/tb_pc_msg_parser.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_msg_parser_if.sv
// Host-command bus between the write FIFO, the parser and the command consumer.
// The master modport is the parser's view; the slave modport is the view of
// the surrounding logic (FIFO read side plus command consumer).
interface pc_msg_parser_if #(
  parameter int XB_SIZE = 32
);
  logic                   pc_msg_valid;
  logic [XB_SIZE-1:0]     pc_msg;
  logic                   pc_msg_ack;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [3*XB_SIZE-1:0]   cmd;
  logic                   cmd_start;
  logic                   cmd_stop;
  logic                   frame_error;
  logic [15:0]            n_cmd;
  logic [7:0]             n_err;

  modport master (
    input  pc_msg_valid,
    input  pc_msg,
    output pc_msg_ack,
    output cmd_valid,
    input  cmd_ready,
    output cmd,
    output cmd_start,
    output cmd_stop,
    output frame_error,
    output n_cmd,
    output n_err
  );

  modport slave (
    output pc_msg_valid,
    output pc_msg,
    input  pc_msg_ack,
    input  cmd_valid,
    output cmd_ready,
    input  cmd,
    input  cmd_start,
    input  cmd_stop,
    input  frame_error,
    input  n_cmd,
    input  n_err
  );
endinterface

// File: rtl/pc_msg_parser.sv
// Host command parser: pops 32-bit words from the FWFT write FIFO, frames them
// into 3-word commands (LSW first), tags each as START (non-zero) or STOP
// (all zero) and hands it to the consumer with a valid/ready handshake.
// A stalled partial command is dropped after TIMEOUT idle cycles so framing
// always recovers from a short host write.
module pc_msg_parser #(
  parameter int XB_SIZE = 32,
  parameter int TIMEOUT = 1024,
  parameter int DELAY   = 1
) (
  input  logic CLK,
  input  logic RESET,
  pc_msg_parser_if.master bus
);

  localparam int CMD_W  = 3 * XB_SIZE;
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  // DELAY is kept so existing instantiations still elaborate; registered
  // assignments here are zero-delay, so it only has to be non-negative.
  if (DELAY < 0) begin : g_delay_range
  end

  typedef enum logic [1:0] {
    S_W0   = 2'd0,
    S_W1   = 2'd1,
    S_W2   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [XB_SIZE-1:0]  word0_q;
  logic [XB_SIZE-1:0]  word1_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [CMD_W-1:0]    cmd_asm;
  logic                cmd_start_q;
  logic                cmd_stop_q;
  logic                frame_error_q;
  logic [15:0]         n_cmd_q;
  logic [7:0]          n_err_q;
  logic [IDLE_W-1:0]   idle_q;

  logic                ack_c;
  logic                cmd_valid_c;
  logic                in_wait;
  logic                timeout_hit;
  logic                handoff;

  // Idle counter step; holds at IDLE_MAX so it can never wrap.
  function automatic logic [IDLE_W-1:0] sat_inc_idle(input logic [IDLE_W-1:0] v);
    return (v == IDLE_MAX) ? v : v + IDLE_W'(1);
  endfunction

  // Error counter step; sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  // The word being accepted in W2 completes the command.
  assign cmd_asm = {bus.pc_msg, word1_q, word0_q};

  assign in_wait     = (state_q == S_W1) || (state_q == S_W2);
  // An accepted word always wins over an expiring idle count.
  assign timeout_hit = (TIMEOUT != 0) && in_wait && !ack_c && (idle_q == IDLE_MAX);
  assign handoff     = cmd_valid_c && bus.cmd_ready;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_W0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: three accepted words fill a command, then hold it
  // until the consumer takes it; a timeout abandons a partial command.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_W0: begin
        if (ack_c) state_d = S_W1;
      end
      S_W1: begin
        if (ack_c)            state_d = S_W2;
        else if (timeout_hit) state_d = S_W0;
      end
      S_W2: begin
        if (ack_c)            state_d = S_HOLD;
        else if (timeout_hit) state_d = S_W0;
      end
      S_HOLD: begin
        if (handoff) state_d = S_W0;
      end
      default: state_d = S_W0;
    endcase
  end

  // Outputs decoded from state: pop whenever a word slot is open, and
  // present the command for the whole time the FSM sits in HOLD.
  always_comb begin
    ack_c       = 1'b0;
    cmd_valid_c = 1'b0;
    ack_c       = bus.pc_msg_valid && (state_q != S_HOLD) && !RESET;
    cmd_valid_c = (state_q == S_HOLD);
  end

  // Word slots for the first two words; they need no reset because the
  // command register only samples them together with a fresh word2.
  always_ff @(posedge CLK) begin
    if (ack_c && (state_q == S_W0)) word0_q <= bus.pc_msg;
    if (ack_c && (state_q == S_W1)) word1_q <= bus.pc_msg;
  end

  // Command register and START/STOP tag, captured with word2.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_q       <= '0;
      cmd_start_q <= 1'b0;
      cmd_stop_q  <= 1'b0;
    end else if (ack_c && (state_q == S_W2)) begin
      cmd_q       <= cmd_asm;
      cmd_stop_q  <= (cmd_asm == '0);
      cmd_start_q <= (cmd_asm != '0);
    end
  end

  // Inter-word idle counter; only runs while a command is partially built.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idle_q <= '0;
    end else if (ack_c || !in_wait || timeout_hit) begin
      idle_q <= '0;
    end else begin
      idle_q <= sat_inc_idle(idle_q);
    end
  end

  // Status: frame_error pulse, handoff count (wraps) and error count (sticks).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_error_q <= 1'b0;
      n_cmd_q       <= 16'd0;
      n_err_q       <= 8'd0;
    end else begin
      frame_error_q <= timeout_hit;
      if (handoff)     n_cmd_q <= n_cmd_q + 16'd1;
      if (timeout_hit) n_err_q <= sat_inc8(n_err_q);
    end
  end

  assign bus.pc_msg_ack  = ack_c;
  assign bus.cmd_valid   = cmd_valid_c;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_start   = cmd_start_q;
  assign bus.cmd_stop    = cmd_stop_q;
  assign bus.frame_error = frame_error_q;
  assign bus.n_cmd       = n_cmd_q;
  assign bus.n_err       = n_err_q;

endmodule

// File: tb/tb_pc_msg_parser.sv
// Directed bench for pc_msg_parser with a small FWFT FIFO model on the input
// and TIMEOUT set to 16 so the inter-word timeout is reachable quickly.
module tb_pc_msg_parser;

  localparam int XB = 32;
  localparam int TO = 16;

  logic CLK;
  logic RESET;

  pc_msg_parser_if #(.XB_SIZE(XB)) dif ();

  pc_msg_parser #(.XB_SIZE(XB), .TIMEOUT(TO), .DELAY(1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (dif.master)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [XB-1:0] fifo_q[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic fifo_refresh();
    dif.pc_msg_valid = (fifo_q.size() != 0);
    dif.pc_msg       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [XB-1:0] w);
    fifo_q.push_back(w);
    fifo_refresh();
  endtask

  // FIFO read side: a word acked at a posedge is popped just after it.
  initial begin
    logic ack_s;
    forever begin
      @(posedge CLK);
      ack_s = dif.pc_msg_ack;
      #1;
      if (ack_s && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        fifo_refresh();
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
  endtask

  // Waits up to budget cycles for cmd_valid; waited is the cycle index or -1.
  task automatic wait_valid(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (dif.cmd_valid === 1'b1) begin
        waited = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    push(32'hdead_beef);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dif.pc_msg_ack !== 1'b0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_miss++;
      $display("FAIL reset_ack: ack high in %0d reset cycles, required 0", bad);
    end
    fifo_q.delete();
    fifo_refresh();
    RESET = 1'b0;
    tick();
    n_vec++;
    if (dif.cmd_valid !== 1'b0 || dif.cmd !== '0 || dif.cmd_start !== 1'b0 ||
        dif.cmd_stop !== 1'b0 || dif.frame_error !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_outputs: valid=%b cmd=%h start=%b stop=%b ferr=%b, required all 0",
               dif.cmd_valid, dif.cmd, dif.cmd_start, dif.cmd_stop, dif.frame_error);
    end
    n_vec++;
    if (dif.n_cmd !== 16'd0 || dif.n_err !== 8'd0) begin
      n_miss++;
      $display("FAIL reset_counts: n_cmd=%0d n_err=%0d, required 0 0", dif.n_cmd, dif.n_err);
    end
  endtask

  task automatic test_stop();
    int w;
    dif.cmd_ready = 1'b1;
    push('0); push('0); push('0);
    wait_valid(10, w);
    n_vec++;
    if (w !== 3) begin
      n_miss++;
      $display("FAIL stop_latency: valid after %0d cycles, required 3", w);
    end
    n_vec++;
    if (dif.cmd !== '0 || dif.cmd_stop !== 1'b1 || dif.cmd_start !== 1'b0) begin
      n_miss++;
      $display("FAIL stop_cmd: cmd=%h stop=%b start=%b, required 0 1 0",
               dif.cmd, dif.cmd_stop, dif.cmd_start);
    end
    tick();
    n_vec++;
    if (dif.cmd_valid !== 1'b0 || dif.n_cmd !== 16'd1) begin
      n_miss++;
      $display("FAIL stop_handoff: valid=%b n_cmd=%0d, required 0 1", dif.cmd_valid, dif.n_cmd);
    end
  endtask

  task automatic test_start();
    int w;
    push(32'h0000_0140); push(32'h0012_0000); push(32'h3c23_d70a);
    wait_valid(10, w);
    n_vec++;
    if (w !== 3) begin
      n_miss++;
      $display("FAIL start_latency: valid after %0d cycles, required 3", w);
    end
    n_vec++;
    if (dif.cmd !== 96'h3c23d70a_00120000_00000140 || dif.cmd_start !== 1'b1 ||
        dif.cmd_stop !== 1'b0) begin
      n_miss++;
      $display("FAIL start_cmd: cmd=%h start=%b stop=%b, required 3c23d70a0012000000000140 1 0",
               dif.cmd, dif.cmd_start, dif.cmd_stop);
    end
    tick();
    n_vec++;
    if (dif.cmd_valid !== 1'b0 || dif.n_cmd !== 16'd2) begin
      n_miss++;
      $display("FAIL start_handoff: valid=%b n_cmd=%0d, required 0 2", dif.cmd_valid, dif.n_cmd);
    end
  endtask

  task automatic test_stall();
    int w;
    int bad;
    bad = 0;
    dif.cmd_ready = 1'b0;
    push(32'h0000_0140); push(32'h0012_0000); push(32'h3c23_d70a);
    push(32'd1); push(32'd2); push(32'd3);
    wait_valid(10, w);
    n_vec++;
    if (w !== 3) begin
      n_miss++;
      $display("FAIL stall_latency: valid after %0d cycles, required 3", w);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dif.pc_msg_ack !== 1'b0 || dif.cmd_valid !== 1'b1 ||
          dif.cmd !== 96'h3c23d70a_00120000_00000140) bad++;
    end
    n_vec++;
    if (bad !== 0 || fifo_q.size() !== 3) begin
      n_miss++;
      $display("FAIL stall_hold: %0d unstable cycles, %0d words queued, required 0 and 3",
               bad, fifo_q.size());
    end
    dif.cmd_ready = 1'b1;
    tick();
    n_vec++;
    if (dif.cmd_valid !== 1'b0 || dif.n_cmd !== 16'd3) begin
      n_miss++;
      $display("FAIL stall_release: valid=%b n_cmd=%0d, required 0 3", dif.cmd_valid, dif.n_cmd);
    end
    wait_valid(10, w);
    n_vec++;
    if (w !== 3 || dif.cmd !== {32'd3, 32'd2, 32'd1} || dif.cmd_start !== 1'b1) begin
      n_miss++;
      $display("FAIL stall_next: after %0d cycles cmd=%h start=%b, required 3 cycles %h 1",
               w, dif.cmd, dif.cmd_start, {32'd3, 32'd2, 32'd1});
    end
    tick();
    n_vec++;
    if (dif.n_cmd !== 16'd4) begin
      n_miss++;
      $display("FAIL stall_count: n_cmd=%0d, required 4", dif.n_cmd);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    int at;
    int w;
    pulses = 0;
    at = -1;
    dif.cmd_ready = 1'b1;
    push(32'h0bad_0001);
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (dif.frame_error === 1'b1) begin
        pulses++;
        at = i;
      end
    end
    n_vec++;
    if (pulses !== 1 || at !== 18) begin
      n_miss++;
      $display("FAIL timeout_pulse: %0d pulses, last at cycle %0d, required 1 at 18", pulses, at);
    end
    n_vec++;
    if (dif.n_err !== 8'd1) begin
      n_miss++;
      $display("FAIL timeout_nerr: n_err=%0d, required 1", dif.n_err);
    end
    push('0); push('0); push('0);
    wait_valid(10, w);
    n_vec++;
    if (w !== 3 || dif.cmd !== '0 || dif.cmd_stop !== 1'b1) begin
      n_miss++;
      $display("FAIL timeout_recover: after %0d cycles cmd=%h stop=%b, required 3 cycles 0 1",
               w, dif.cmd, dif.cmd_stop);
    end
    tick();
  endtask

  task automatic test_timeout_edge();
    int pulses;
    int at;
    logic [95:0] got;
    pulses = 0;
    at = -1;
    got = '0;
    push(32'h1111_0001);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (dif.frame_error === 1'b1) pulses++;
      if (dif.cmd_valid === 1'b1) begin
        at = i;
        got = dif.cmd;
      end
      if (i == 16) push(32'h2222_0002);
      if (i == 33) push(32'h3333_0003);
    end
    n_vec++;
    if (pulses !== 0 || dif.n_err !== 8'd1) begin
      n_miss++;
      $display("FAIL edge_no_error: %0d pulses n_err=%0d, required 0 and 1", pulses, dif.n_err);
    end
    n_vec++;
    if (at !== 34 || got !== 96'h3333_0003_2222_0002_1111_0001) begin
      n_miss++;
      $display("FAIL edge_cmd: valid at %0d cmd=%h, required 34 333300032222000211110001",
               at, got);
    end
  endtask

  task automatic test_err_saturate();
    int missed;
    bit seen;
    missed = 0;
    for (int k = 0; k < 256; k++) begin
      push(32'h5a5a_0000 | k);
      seen = 1'b0;
      for (int i = 0; i < 25 && !seen; i++) begin
        tick();
        if (dif.frame_error === 1'b1) seen = 1'b1;
      end
      if (!seen) missed++;
    end
    n_vec++;
    if (missed !== 0 || dif.n_err !== 8'd255) begin
      n_miss++;
      $display("FAIL err_saturate: %0d timeouts missed n_err=%0d, required 0 and 255",
               missed, dif.n_err);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    int t[2];
    logic [95:0] c[2];
    logic s[2];
    cnt = 0;
    t[0] = -1; t[1] = -1;
    c[0] = '1; c[1] = '1;
    s[0] = 1'b0; s[1] = 1'b0;
    push(32'h7777_7777);
    tick(); tick();
    apply_reset();
    n_vec++;
    if (dif.n_err !== 8'd0 || dif.n_cmd !== 16'd0 || dif.cmd_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL midreset: n_err=%0d n_cmd=%0d valid=%b, required 0 0 0",
               dif.n_err, dif.n_cmd, dif.cmd_valid);
    end
    dif.cmd_ready = 1'b1;
    push('0); push('0); push('0);
    push(32'h0000_0140); push(32'h0012_0000); push(32'h3c23_d70a);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dif.cmd_valid === 1'b1) begin
        if (cnt < 2) begin
          t[cnt] = i;
          c[cnt] = dif.cmd;
          s[cnt] = dif.cmd_stop;
        end
        cnt++;
      end
    end
    n_vec++;
    if (cnt !== 2 || t[0] !== 3 || t[1] !== 7) begin
      n_miss++;
      $display("FAIL b2b_timing: %0d handoffs at %0d and %0d, required 2 at 3 and 7",
               cnt, t[0], t[1]);
    end
    n_vec++;
    if (c[0] !== '0 || s[0] !== 1'b1 || c[1] !== 96'h3c23d70a_00120000_00000140 ||
        s[1] !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_cmds: %h/%b then %h/%b, required 0/1 then 3c23d70a0012000000000140/0",
               c[0], s[0], c[1], s[1]);
    end
    n_vec++;
    if (dif.n_cmd !== 16'd2) begin
      n_miss++;
      $display("FAIL b2b_count: n_cmd=%0d, required 2", dif.n_cmd);
    end
  endtask

  initial begin
    RESET = 1'b1;
    dif.cmd_ready = 1'b0;
    fifo_refresh();
    test_reset();
    test_stop();
    test_start();
    test_stall();
    test_timeout();
    test_timeout_edge();
    test_err_saturate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
